// File: rtl/eth_vlg_pkg.sv
// eth_vlg_pkg
// Shared constants and types for the eth_vlg receive path.
//   ETHERTYPE_ARP / ETHERTYPE_IPV4 : EtherType values of the default consumers
//   MAC_BROADCAST                  : all-ones destination MAC
//   rx_demux_fsm_t                 : receive demultiplexer state encoding
package eth_vlg_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } rx_demux_fsm_t;

endpackage

// File: rtl/eth_vlg_rx_demux_lut.sv
// eth_vlg_rx_demux_lut
// Combinational EtherType-to-port lookup.
//   ethertype : EtherType to look up
//   hit       : some port serves this EtherType
//   sel       : one-hot port select, same packing as ETHERTYPES
//               (port i sits at packed index N-1-i, port 0 is the MSB entry)
// When several ports serve the same EtherType the lowest port index wins.
module eth_vlg_rx_demux_lut
  import eth_vlg_pkg::*;
#(
  parameter int                 N          = 2,
  parameter logic [N-1:0][15:0] ETHERTYPES = {ETHERTYPE_ARP, ETHERTYPE_IPV4}
)(
  input  logic [15:0]  ethertype,
  output logic         hit,
  output logic [N-1:0] sel
);

  // Packed index k ascends from port N-1 towards port 0, so the last match
  // written is the lowest port index.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (ETHERTYPES[k] == ethertype) begin
        hit    = 1'b1;
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_vlg_rx_demux.sv
// eth_vlg_rx_demux
// Dispatches the MAC receive byte stream to N upper-layer consumers by
// EtherType, filtering on destination MAC and truncating frames at MTU.
// Outputs are registered: a byte accepted at cycle t appears at t+1.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   mac_addr       : own MAC address
//   in_*           : MAC receive stream (ethertype/dst_mac valid with in_sof)
//   out_dat        : payload byte, shared by all consumers
//   out_val        : one-hot per-port valid (port i at bit N-1-i)
//   out_sof/eof    : frame delimiters
//   out_err        : frame errored or truncated
//   out_ethertype  : EtherType of the frame being delivered
//   drop_cnt       : saturating count of dropped frames
//   port_frames    : per-port clean-frame counters (port i at slot N-1-i);
//                    only populated when ETH_VLG_RX_DEMUX_STATS_EN is defined
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for in_val & in_sof
// FWD   | forwarding the current frame to the latched port
// DROP  | discarding bytes until in_val & in_eof
module eth_vlg_rx_demux
  import eth_vlg_pkg::*;
#(
  parameter int                 N          = 2,
  parameter logic [N-1:0][15:0] ETHERTYPES = {ETHERTYPE_ARP, ETHERTYPE_IPV4},
  parameter int                 MTU        = 1500,
  parameter bit                 PROMISC    = 1'b0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [47:0]     mac_addr,
  input  logic [7:0]      in_dat,
  input  logic            in_val,
  input  logic            in_sof,
  input  logic            in_eof,
  input  logic            in_err,
  input  logic [15:0]     in_ethertype,
  input  logic [47:0]     in_dst_mac,
  output logic [7:0]      out_dat,
  output logic [N-1:0]    out_val,
  output logic            out_sof,
  output logic            out_eof,
  output logic            out_err,
  output logic [15:0]     out_ethertype,
  output logic [31:0]     drop_cnt,
  output logic [N*32-1:0] port_frames
);

  localparam logic [15:0] MTU_W = 16'(MTU);

  rx_demux_fsm_t state_q, state_d;
  logic [N-1:0]  port_q, port_d;
  logic [15:0]   cnt_q, cnt_d, cnt_inc;
  logic          sticky_q, sticky_d;

  logic          lut_hit;
  logic [N-1:0]  lut_sel;
  logic          dst_ok;

  logic          emit;
  logic [N-1:0]  val_port;
  logic          sof_d, eof_d, err_d;
  logic [15:0]   et_d;
  logic          drop_inc;

  logic [7:0]    out_dat_q;
  logic [N-1:0]  out_val_q;
  logic          out_sof_q, out_eof_q, out_err_q;
  logic [15:0]   out_et_q;
  logic [31:0]   drop_cnt_q;

  eth_vlg_rx_demux_lut #(
    .N          (N),
    .ETHERTYPES (ETHERTYPES)
  ) u_lut (
    .ethertype (in_ethertype),
    .hit       (lut_hit),
    .sel       (lut_sel)
  );

  assign dst_ok  = PROMISC || (in_dst_mac == mac_addr) || (in_dst_mac == MAC_BROADCAST);
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    emit     = 1'b0;
    val_port = port_q;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    et_d     = out_et_q;
    drop_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_val && in_sof) begin
          if (dst_ok && lut_hit) begin
            emit     = 1'b1;
            val_port = lut_sel;
            port_d   = lut_sel;
            et_d     = in_ethertype;
            sof_d    = 1'b1;
            err_d    = in_err;
            cnt_d    = 16'd1;
            if (in_eof) begin
              eof_d = 1'b1;
            end else if (MTU_W == 16'd1) begin
              // First byte already fills the MTU: truncate immediately.
              eof_d   = 1'b1;
              err_d   = 1'b1;
              state_d = DROP;
            end else begin
              sticky_d = in_err;
              state_d  = FWD;
            end
          end else begin
            drop_inc = 1'b1;
            // A rejected single-byte frame is already complete.
            if (!in_eof) state_d = DROP;
          end
        end
      end

      FWD: begin
        if (in_val) begin
          emit     = 1'b1;
          cnt_d    = cnt_inc;
          err_d    = in_err | sticky_q;
          sticky_d = sticky_q | in_err;
          if (in_sof) begin
            // Previous frame never ended: close it as errored, drop the new one.
            eof_d    = 1'b1;
            err_d    = 1'b1;
            sticky_d = 1'b0;
            drop_inc = 1'b1;
            state_d  = in_eof ? IDLE : DROP;
          end else if (in_eof) begin
            eof_d    = 1'b1;
            sticky_d = 1'b0;
            state_d  = IDLE;
          end else if (cnt_inc == MTU_W) begin
            eof_d    = 1'b1;
            err_d    = 1'b1;
            sticky_d = 1'b0;
            state_d  = DROP;
          end
        end
      end

      DROP: begin
        if (in_val) begin
          if (in_sof) drop_inc = 1'b1;
          if (in_eof) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      out_dat_q  <= '0;
      out_val_q  <= '0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_err_q  <= 1'b0;
      out_et_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      out_val_q <= emit ? val_port : '0;
      out_sof_q <= sof_d;
      out_eof_q <= eof_d;
      out_err_q <= err_d;
      out_et_q  <= et_d;
      if (emit) out_dat_q <= in_dat;
      if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign out_dat       = out_dat_q;
  assign out_val       = out_val_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign out_err       = out_err_q;
  assign out_ethertype = out_et_q;
  assign drop_cnt      = drop_cnt_q;

`ifdef ETH_VLG_RX_DEMUX_STATS_EN
  logic [N-1:0][31:0] frames_q;

  // Counts from the registered outputs, so a frame shows up one cycle
  // after its eof is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (out_val_q[k] && out_eof_q && !out_err_q && (frames_q[k] != 32'hFFFF_FFFF))
          frames_q[k] <= frames_q[k] + 32'd1;
      end
    end
  end

  assign port_frames = frames_q;
`else
  assign port_frames = '0;
`endif

endmodule

// File: tb/tb_eth_vlg_rx_demux.sv
// tb_eth_vlg_rx_demux
// Scoreboard bench: the driver feeds bytes to a frame-level reference model
// that queues expected output beats; a monitor pops and compares on every
// cycle where out_val is non-zero.
module tb_eth_vlg_rx_demux;

  localparam int          N         = 2;
  localparam int          MTU       = 64;
  localparam logic [47:0] MY_MAC    = 48'h02_1A_2B_3C_4D_5E;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER_MAC = 48'h42_55_92_16_EE_32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [47:0]     mac_addr = MY_MAC;
  logic [7:0]      in_dat = '0;
  logic            in_val = 1'b0;
  logic            in_sof = 1'b0;
  logic            in_eof = 1'b0;
  logic            in_err = 1'b0;
  logic [15:0]     in_ethertype = '0;
  logic [47:0]     in_dst_mac = '0;
  logic [7:0]      out_dat;
  logic [N-1:0]    out_val;
  logic            out_sof, out_eof, out_err;
  logic [15:0]     out_ethertype;
  logic [31:0]     drop_cnt;
  logic [N*32-1:0] port_frames;

  always #5 clk = ~clk;

  eth_vlg_rx_demux #(
    .N          (N),
    .ETHERTYPES ({16'h0806, 16'h0800}),
    .MTU        (MTU),
    .PROMISC    (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mac_addr      (mac_addr),
    .in_dat        (in_dat),
    .in_val        (in_val),
    .in_sof        (in_sof),
    .in_eof        (in_eof),
    .in_err        (in_err),
    .in_ethertype  (in_ethertype),
    .in_dst_mac    (in_dst_mac),
    .out_dat       (out_dat),
    .out_val       (out_val),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_err       (out_err),
    .out_ethertype (out_ethertype),
    .drop_cnt      (drop_cnt),
    .port_frames   (port_frames)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0]   dat;
    logic [N-1:0] val;
    logic         sof;
    logic         eof;
    logic         err;
    logic [15:0]  et;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    beats_port[N];

  // Reference model: per port list of served EtherTypes (port 0 first).
  logic [15:0] port_types[N] = '{16'h0806, 16'h0800};
  int          m_mode;   // 0: between frames, 1: delivering, 2: discarding
  int          m_port;
  int          m_len;
  bit          m_bad;
  logic [15:0] m_et;
  int          m_drops;
  int          m_good[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [15:0] et);
    for (int p = 0; p < N; p++) if (port_types[p] == et) return p;
    return -1;
  endfunction

  function automatic void push(input logic [7:0] d, input int p, input bit s, input bit e, input bit r);
    beat_t b;
    b.dat = d;
    b.val = '0;
    b.val[N-1-p] = 1'b1;
    b.sof = s;
    b.eof = e;
    b.err = r;
    b.et  = m_et;
    exp_q.push_back(b);
    if (e && !r) m_good[p]++;
  endfunction

  function automatic void model_reset();
    m_mode  = 0;
    m_drops = 0;
    for (int p = 0; p < N; p++) m_good[p] = 0;
  endfunction

  function automatic void model_byte(input bit sof, input bit eof, input bit err,
                                     input logic [7:0] d, input logic [15:0] et,
                                     input logic [47:0] dst);
    int p;
    if (m_mode == 0) begin
      if (!sof) return;
      p = lookup(et);
      if (p < 0 || !(dst == MY_MAC || dst == BCAST)) begin
        m_drops++;
        m_mode = eof ? 0 : 2;
      end else begin
        m_port = p;
        m_et   = et;
        m_len  = 1;
        m_bad  = err;
        if (eof)             push(d, p, 1, 1, err);
        else if (m_len == MTU) begin push(d, p, 1, 1, 1); m_mode = 2; end
        else begin           push(d, p, 1, 0, err); m_mode = 1; end
      end
    end else if (m_mode == 1) begin
      m_len++;
      m_bad = m_bad | err;
      if (sof) begin
        push(d, m_port, 0, 1, 1);
        m_drops++;
        m_mode = eof ? 0 : 2;
      end else if (eof) begin
        push(d, m_port, 0, 1, m_bad);
        m_mode = 0;
      end else if (m_len == MTU) begin
        push(d, m_port, 0, 1, 1);
        m_mode = 2;
      end else begin
        push(d, m_port, 0, 0, m_bad);
      end
    end else begin
      if (sof) m_drops++;
      if (eof) m_mode = 0;
    end
  endfunction

  function automatic logic [N*32-1:0] exp_frames();
    logic [N*32-1:0] v = '0;
`ifdef ETH_VLG_RX_DEMUX_STATS_EN
    for (int p = 0; p < N; p++) v[(N-1-p)*32 +: 32] = 32'(m_good[p]);
`endif
    return v;
  endfunction

  function automatic logic [47:0] junk48();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic drive_byte(input bit v, input bit s, input bit e, input bit r,
                            input logic [7:0] d, input logic [15:0] et, input logic [47:0] dst);
    @(posedge clk);
    #1;
    in_val       = v;
    in_sof       = s;
    in_eof       = e;
    in_err       = r;
    in_dat       = d;
    in_ethertype = et;
    in_dst_mac   = dst;
    if (v) model_byte(s, e, r, d, et, dst);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++)
      drive_byte(0, $urandom_range(1, 0), $urandom_range(1, 0), 0, 8'($urandom), 16'($urandom), junk48());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_val"}, 64'(out_val), 0);
    check({tag, "_dat"}, 64'(out_dat), 0);
    check({tag, "_flags"}, 64'({out_sof, out_eof, out_err}), 0);
    check({tag, "_et"}, 64'(out_ethertype), 0);
    check({tag, "_drop"}, 64'(drop_cnt), 0);
    check({tag, "_frames"}, 64'(port_frames), 0);
  endtask

  // Reset asserted while byte rst_at is on the bus; the rest of the frame
  // continues with no sof and must be ignored.
  task automatic send_frame(input logic [15:0] et, input logic [47:0] dst, input int len,
                            input int err_at, input bit term, input int gap_every,
                            input logic [7:0] base, input int rst_at);
    for (int i = 0; i < len; i++) begin
      if (gap_every > 0 && i > 0 && (i % gap_every) == 0) drive_idle(1);
      if (i == rst_at) begin
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_val = 1'b1;
        in_sof = 1'b0;
        in_eof = 1'b0;
        in_dat = 8'(int'(base) + i);
        model_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        in_val = 1'b0;
        check_outputs_zero("rst_mid");
      end else begin
        drive_byte(1, i == 0, term && (i == len - 1), i == err_at, 8'(int'(base) + i),
                   (i == 0) ? et : 16'($urandom), (i == 0) ? dst : junk48());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_val !== '0) begin
        for (int p = 0; p < N; p++) if (out_val[N-1-p]) beats_port[p]++;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_beat: got val=%b dat=%h sof=%b eof=%b err=%b, required no beat",
                   out_val, out_dat, out_sof, out_eof, out_err);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_val !== mon_e.val || out_dat !== mon_e.dat || out_sof !== mon_e.sof ||
              out_eof !== mon_e.eof || out_err !== mon_e.err || out_ethertype !== mon_e.et) begin
            failed++;
            $display("FAIL beat: got val=%b dat=%h sof=%b eof=%b err=%b et=%h, required val=%b dat=%h sof=%b eof=%b err=%b et=%h",
                     out_val, out_dat, out_sof, out_eof, out_err, out_ethertype,
                     mon_e.val, mon_e.dat, mon_e.sof, mon_e.eof, mon_e.err, mon_e.et);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int r;
    int len;
    logic [15:0] et;
    logic [47:0] dst;

    model_reset();
    for (int p = 0; p < N; p++) beats_port[p] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // 1: IPv4 unicast, 46 bytes 0x00..0x2D
    b0 = beats_port[1];
    send_frame(16'h0800, MY_MAC, 46, -1, 1, 0, 8'h00, -1);
    drive_idle(3);
    check("t1_port1_beats", 64'(beats_port[1] - b0), 46);
    check("t1_drop", 64'(drop_cnt), 0);

    // 2: ARP broadcast with 3 gaps, then a frame for another station
    b0 = beats_port[0];
    send_frame(16'h0806, BCAST, 28, -1, 1, 9, 8'h40, -1);
    send_frame(16'h0800, OTHER_MAC, 20, -1, 1, 0, 8'h80, -1);
    drive_idle(3);
    check("t2_port0_beats", 64'(beats_port[0] - b0), 28);
    check("t2_drop", 64'(drop_cnt), 1);

    // 3: unknown EtherType, then a good IPv4 frame
    send_frame(16'h86DD, MY_MAC, 30, -1, 1, 0, 8'h10, -1);
    send_frame(16'h0800, MY_MAC, 12, -1, 1, 0, 8'h20, -1);
    drive_idle(3);
    check("t3_drop", 64'(drop_cnt), 2);

    // 4: 100-byte frame against MTU=64
    b0 = beats_port[1];
    send_frame(16'h0800, MY_MAC, 100, -1, 1, 0, 8'h00, -1);
    drive_idle(3);
    check("t4_port1_beats", 64'(beats_port[1] - b0), MTU);
    check("t4_drop", 64'(drop_cnt), 2);

    // 5: error mid-frame; then a frame interrupted by a new sof
    send_frame(16'h0800, MY_MAC, 20, 10, 1, 0, 8'h30, -1);
    send_frame(16'h0800, MY_MAC, 15, -1, 0, 0, 8'h50, -1);
    send_frame(16'h0806, MY_MAC, 10, -1, 1, 0, 8'h70, -1);
    drive_idle(3);
    check("t5_drop", 64'(drop_cnt), 3);

    // 6: reset at byte 5 of 20, then three clean IPv4 frames
    send_frame(16'h0800, MY_MAC, 20, -1, 1, 0, 8'h90, 5);
    drive_idle(2);
    for (int k = 0; k < 3; k++) send_frame(16'h0800, BCAST, 8 + k, -1, 1, 0, 8'(k * 16), -1);
    drive_idle(3);
    check("t6_drop", 64'(drop_cnt), 0);
    check("t6_frames", 64'(port_frames), 64'(exp_frames()));

    // Random traffic
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(9, 0);
      if (r < 4)      et = 16'h0800;
      else if (r < 7) et = 16'h0806;
      else if (r < 8) et = 16'h86DD;
      else            et = 16'($urandom);
      r = $urandom_range(9, 0);
      if (r < 5)      dst = MY_MAC;
      else if (r < 8) dst = BCAST;
      else            dst = junk48();
      len = $urandom_range(70, 1);
      send_frame(et, dst, len,
                 ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 0) : -1,
                 $urandom_range(9, 0) != 0,
                 ($urandom_range(1, 0) == 1) ? $urandom_range(8, 2) : 0,
                 8'($urandom), -1);
      if ($urandom_range(4, 0) == 0)
        drive_byte(1, 0, 1, 0, 8'($urandom), 16'($urandom), junk48());
      drive_idle($urandom_range(2, 0));
    end
    drive_byte(1, 0, 1, 0, 8'h00, 16'h0000, 48'h0);
    drive_idle(4);

    check("final_queue_drained", 64'(exp_q.size()), 0);
    check("final_drop", 64'(drop_cnt), 64'(m_drops));
    check("final_frames", 64'(port_frames), 64'(exp_frames()));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/eth_vlg_rx_demux.md
Name: eth_vlg_rx_demux

Overview:
- Receive-side counterpart of the transmit arbiter: takes the single MAC receive byte stream and dispatches each frame to one of N upper-layer consumers (ARP, IPv4, ...).
- Selects the consumer from the frame's EtherType.
- Filters frames by destination MAC, enforces a maximum payload length and counts dropped frames.
- Sits between the MAC core and the ARP and IPv4 receive paths, replacing the present broadcast-to-all scheme.

Parameters:
- N, 2, number of consumer ports.
- ETHERTYPES, {16'h0806,16'h0800}, packed [N-1:0][15:0]; EtherType served by each port. Port 0 is the most significant entry.
- MTU, 1500, maximum payload bytes per frame. Range 1..65535.
- PROMISC, 0, when 1 the destination-MAC filter is disabled.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mac_addr  in  48  device MAC address.
- in_dat  in  8  payload byte.
- in_val  in  1  byte valid.
- in_sof  in  1  first payload byte; qualified by in_val.
- in_eof  in  1  last payload byte; qualified by in_val.
- in_err  in  1  MAC error flag (FCS or PHY error); qualified by in_val.
- in_ethertype  in  16  frame EtherType; valid with in_sof.
- in_dst_mac  in  48  destination MAC; valid with in_sof.
- out_dat  out  8  payload byte; data bus shared by all ports.
- out_val  out  N  one-hot valid, one bit per port.
- out_sof  out  1  first byte of frame.
- out_eof  out  1  last byte of frame.
- out_err  out  1  frame errored; meaningful when any out_val bit is set.
- out_ethertype  out  16  EtherType of the current frame; held from sof through eof.
- drop_cnt  out  32  saturating count of dropped frames.
- port_frames  out  N*32  per-port forwarded-frame counts. Populated only with the optional feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; sticky error 0.
- Latency: one register stage. An input byte at cycle t appears at the outputs at t+1.
- No backpressure. Idle gaps (in_val=0) are allowed anywhere; nothing is emitted during a gap.
- States: IDLE, FWD, DROP.

IDLE:
- in_val&in_sof is the only event. Any other input is ignored, including an eof with no preceding sof.
- Destination accepted when in_dst_mac==mac_addr, or in_dst_mac==48'hFFFFFFFFFFFF, or PROMISC=1.
- Port lookup: the lowest index i with ETHERTYPES[i]==in_ethertype.
- Accept and match: latch the selected port and in_ethertype; emit the byte with out_sof=1; counter=1; go to FWD.
- Either check fails: drop_cnt+1, saturating at 32'hFFFFFFFF; go to DROP. No output.
- in_sof&in_eof together (1-byte frame), accepted: emit with out_sof=out_eof=1 and stay in IDLE.

FWD:
- Each valid byte is emitted on the latched port.
- Sticky error |= in_err. out_err = in_err | sticky.
- in_eof: emit with out_eof=1; go to IDLE; clear sticky.
- Counter reaches MTU and in_eof=0: emit that byte with out_eof=1 and out_err=1; go to DROP. This is not counted as a drop.
- in_sof arrives (unterminated previous frame): emit the byte on the old port with out_eof=1 and out_err=1. The new frame is discarded: drop_cnt+1; go to DROP, or to IDLE if in_eof is also set.

DROP:
- Discard bytes until in_val&in_eof, then go to IDLE.
- An in_sof seen in DROP is treated as the start of a new discarded frame: drop_cnt+1; stay in DROP.

Arithmetic:
- Byte counter is 16 bits.
- Comparison against MTU is exact equality.

Reset mid-frame:
- Returns to IDLE immediately; no eof is emitted to any consumer.
- Consumers must reset together with this block.

Optional Feature:
- Macro: ETH_VLG_RX_DEMUX_STATS_EN.
- Defined: port_frames[i] increments, saturating, on every out_eof with out_err=0 delivered to port i.
- Not defined: port_frames is tied to 0 and no counter logic is synthesised. The port list is unchanged.

Decomposition:
- eth_vlg_pkg holds:
  - constants ETHERTYPE_ARP=16'h0806 and ETHERTYPE_IPV4=16'h0800;
  - MAC_BROADCAST=48'hFFFFFFFFFFFF;
  - enum rx_demux_fsm_t {IDLE,FWD,DROP}.
- Sub-module eth_vlg_rx_demux_lut: combinational EtherType-to-port lookup over ETHERTYPES. Outputs are hit and a one-hot select with lowest-index priority.

Test Plan:
1. IPv4 unicast: dst=mac_addr, type 0x0800, 46 bytes 0x00..0x2D -> out_val=2'b01 (port 1) for 46 cycles; sof on byte 0x00, eof on byte 0x2D; out_err=0; each byte one cycle later; drop_cnt=0.
2. ARP broadcast: dst=FF:FF:FF:FF:FF:FF, type 0x0806, 28 bytes with 3 idle gaps -> port 0 receives 28 bytes, no output during gaps; a following frame to 42:55:92:16:EE:32 -> no output, drop_cnt=1.
3. Unknown type 0x86DD, dst=mac_addr -> fully discarded, drop_cnt increments by 1; the next IPv4 frame forwards correctly.
4. MTU=64 with a 100-byte IPv4 frame -> 64 bytes out, byte 64 carries eof and err; the remaining 36 discarded; drop_cnt unchanged.
5. in_err on byte 10 of a 20-byte frame -> out_err=1 from byte 10 through eof. Sof at byte 15 of a frame lacking eof -> eof+err on the old port; new frame dropped; drop_cnt+1.
6. rst asserted at byte 5 of 20 -> all outputs 0 next cycle; the remaining 15 bytes ignored; the next valid frame forwards. With ETH_VLG_RX_DEMUX_STATS_EN, 3 clean IPv4 frames -> port_frames[1]=3.
